// File: rtl/fsm_stim_gen_pkg.sv
// Shared types and constants for the serial stimulus generator and its
// shadow model of the 5-state Moore detector.
package fsm_stim_gen_pkg;

   localparam int MAX_LEN_DEFAULT = 8;

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } det_state_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/fsm5_model.sv
// Combinational next-state and output logic of the 5-state Moore detector,
// usable both as the generator's shadow and as a reference elsewhere.
module fsm5_model
   import fsm_stim_gen_pkg::*;
(
   input  det_state_t state,
   input  logic       x,
   output det_state_t next_state,
   output logic       y
);

   always_comb begin
      next_state = S0;
      unique case (state)
         S0: next_state = x ? S1 : S0;
         S1: next_state = x ? S4 : S2;
         S2: next_state = x ? S0 : S3;
         S3: next_state = x ? S3 : S4;
         S4: next_state = x ? S2 : S1;
         // Unused encodings recover to the initial state
         default: next_state = S0;
      endcase
   end

   assign y = (state == S0);

endmodule

// File: rtl/fsm_stim_gen.sv
// Serialises a pattern MSB first for the Moore detector while tracking the
// state that detector should be in after each bit that has been sent.
module fsm_stim_gen
   import fsm_stim_gen_pkg::*;
#(
   parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [3:0]         len,
   output logic               x,
   output logic               x_valid,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [2:0]         pred_state,
   output logic               pred_y
);

   ctrl_state_t        state;
   ctrl_state_t        next_state;
   logic [MAX_LEN-1:0] shreg;
   logic [3:0]         count;
   det_state_t         pred;
   det_state_t         pred_next;
   logic               err_q;
   logic               len_ok;
   logic               accept;
   logic               reject;

   assign len_ok = (len != 4'd0) && ({28'd0, len} <= 32'(MAX_LEN));
   assign accept = (state == IDLE) && start && len_ok;
   assign reject = (state == IDLE) && start && !len_ok;

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (accept) next_state = SHIFT;
         SHIFT:   if (count == 4'd1) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // The shadow advances on the very bit presented on x, so it always
   // reflects the bits the detector has already consumed.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         shreg <= '0;
         count <= 4'd0;
         pred  <= S0;
         err_q <= 1'b0;
      end else begin
         state <= next_state;
         err_q <= reject;
         if (accept) begin
            shreg <= pattern;
            count <= len;
            pred  <= S0;
         end else if (state == SHIFT) begin
            shreg <= {shreg[MAX_LEN-2:0], 1'b0};
            count <= count - 4'd1;
            pred  <= pred_next;
         end
      end
   end

   fsm5_model u_model (
      .state      (pred),
      .x          (x),
      .next_state (pred_next),
      .y          (pred_y)
   );

   assign x_valid    = (state == SHIFT);
   assign x          = (state == SHIFT) && shreg[MAX_LEN-1];
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);
   assign err        = err_q;
   assign pred_state = pred;

endmodule

// File: tb/tb_fsm_stim_gen.sv
// Directed and randomised checks of fsm_stim_gen against a bit-list model
// of the detector transitions.
module tb_fsm_stim_gen;

   localparam int MAX_LEN = 8;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic [MAX_LEN-1:0] pattern;
   logic [3:0]         len;
   logic               x;
   logic               x_valid;
   logic               busy;
   logic               done;
   logic               err;
   logic [2:0]         pred_state;
   logic               pred_y;

   int vectors    = 0;
   int miscompares = 0;
   int model_pred = 0;
   int next_on0 [5] = '{0, 2, 3, 4, 1};
   int next_on1 [5] = '{1, 4, 0, 3, 2};

   fsm_stim_gen #(.MAX_LEN(MAX_LEN)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .pattern    (pattern),
      .len        (len),
      .x          (x),
      .x_valid    (x_valid),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .pred_state (pred_state),
      .pred_y     (pred_y)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic s, input logic [MAX_LEN-1:0] p, input logic [3:0] l);
      start   = s;
      pattern = p;
      len     = l;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic check_quiet(input string tag);
      check_output({tag, ".x_valid"}, 32'(x_valid), 0);
      check_output({tag, ".x"}, 32'(x), 0);
      check_output({tag, ".busy"}, 32'(busy), 0);
      check_output({tag, ".done"}, 32'(done), 0);
      check_output({tag, ".pred_state"}, 32'(pred_state), 32'(model_pred));
      check_output({tag, ".pred_y"}, 32'(pred_y), 32'(model_pred == 0));
   endtask

   // restart_at: SHIFT cycle on which a second start is raised (0 = never)
   task automatic run_transfer(input logic [MAX_LEN-1:0] pat, input int n,
                               input int restart_at, input bit start_at_done);
      bit b;
      apply_stimulus(1'b1, pat, 4'(n));
      tick();
      apply_stimulus(1'b0, '0, 4'd0);
      model_pred = 0;
      for (int i = 1; i <= n; i++) begin
         b = pat[MAX_LEN-i];
         check_output("shift.x_valid", 32'(x_valid), 1);
         check_output("shift.x", 32'(x), 32'(b));
         check_output("shift.busy", 32'(busy), 1);
         check_output("shift.done", 32'(done), 0);
         check_output("shift.err", 32'(err), 0);
         check_output("shift.pred_state", 32'(pred_state), 32'(model_pred));
         check_output("shift.pred_y", 32'(pred_y), 32'(model_pred == 0));
         model_pred = b ? next_on1[model_pred] : next_on0[model_pred];
         if (i == restart_at) apply_stimulus(1'b1, ~pat, 4'd2);
         else                 apply_stimulus(1'b0, '0, 4'd0);
         tick();
      end
      check_output("done.done", 32'(done), 1);
      check_output("done.busy", 32'(busy), 1);
      check_output("done.x_valid", 32'(x_valid), 0);
      check_output("done.x", 32'(x), 0);
      check_output("done.err", 32'(err), 0);
      check_output("done.pred_state", 32'(pred_state), 32'(model_pred));
      check_output("done.pred_y", 32'(pred_y), 32'(model_pred == 0));
      if (start_at_done) apply_stimulus(1'b1, 8'hA0, 4'd3);
      else               apply_stimulus(1'b0, '0, 4'd0);
      tick();
      apply_stimulus(1'b0, '0, 4'd0);
      check_quiet("after");
      check_output("after.err", 32'(err), 0);
   endtask

   task automatic reject_start(input logic [3:0] l);
      apply_stimulus(1'b1, 8'hFF, l);
      tick();
      apply_stimulus(1'b0, '0, 4'd0);
      check_output("reject.err", 32'(err), 1);
      check_quiet("reject");
      tick();
      check_output("reject.err_clear", 32'(err), 0);
      check_quiet("reject_idle");
   endtask

   initial begin
      int n;
      int r;
      reset = 1'b1;
      apply_stimulus(1'b1, 8'hE0, 4'd3);
      tick();
      tick();
      model_pred = 0;
      check_quiet("reset");
      check_output("reset.err", 32'(err), 0);
      reset = 1'b0;
      apply_stimulus(1'b0, '0, 4'd0);
      tick();
      check_quiet("post_reset");

      $display("[TB] directed transfers");
      run_transfer(8'b1000_0000, 1, 0, 1'b0);
      run_transfer(8'b1110_0000, 3, 0, 1'b0);
      run_transfer(8'b1010_0000, 3, 0, 1'b0);
      reject_start(4'd0);
      reject_start(4'd9);
      run_transfer(8'b0110_0000, 4, 2, 1'b0);
      run_transfer(8'b1101_0011, 8, 0, 1'b1);

      $display("[TB] reset during SHIFT");
      apply_stimulus(1'b1, 8'b1111_1111, 4'd8);
      tick();
      apply_stimulus(1'b0, '0, 4'd0);
      tick();
      tick();
      check_output("abort.x_valid_before", 32'(x_valid), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_pred = 0;
      check_quiet("abort");
      check_output("abort.err", 32'(err), 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check_output("abort.no_done", 32'(done), 0);
         check_output("abort.no_valid", 32'(x_valid), 0);
      end

      $display("[TB] randomised transfers");
      for (int k = 0; k < 40; k++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0) begin
            if ($urandom_range(0, 1) == 0) reject_start(4'd0);
            else reject_start(4'($urandom_range(MAX_LEN + 1, 15)));
         end else begin
            n = int'($urandom_range(1, MAX_LEN));
            run_transfer(MAX_LEN'($urandom), n, int'($urandom_range(0, n)),
                         1'($urandom_range(0, 1)));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
